cmdout_collector: RTL and testbench

Aggregates task-completion command words from NUM_ACCS accelerators into the single cmdout input stream of the OmpSs manager. It feeds the manager's cmdout_in_tvalid/tready/tid/tdata.
- Each accelerator gets a one-entry holding slot.
- A round-robin arbiter moves slots into a registered output stage.
- The output stage tags each word with the source accelerator index on TID.
- A delivered-message counter is exposed for debug.

---
 rtl/cmdout_collector.sv | 96 +++++++++
 tb/tb_cmdout_collector.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmdout_collector.sv
// Collects 64-bit completion words from NUM_ACCS accelerators into one AXI-Stream
// cmdout channel. Each source has a one-entry slot, and a round-robin grant feeds a registered output stage.
module cmdout_collector #(
  parameter int NUM_ACCS    = 16,
  parameter int ACC_BITS    = $clog2(NUM_ACCS),
  parameter int COUNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_ACCS-1:0]      acc_in_tvalid,
  output logic [NUM_ACCS-1:0]      acc_in_tready,
  input  logic [NUM_ACCS*64-1:0]   acc_in_tdata,
  output logic                     cmdout_tvalid,
  input  logic                     cmdout_tready,
  output logic [ACC_BITS-1:0]      cmdout_tid,
  output logic [63:0]              cmdout_tdata,
  output logic [COUNT_WIDTH-1:0]   msg_count
);

  // Handshake: a word moves on a rising edge where valid & ready are both high.
  // Valid never waits for ready, and ready here is a function of registered slot state only.
  logic [NUM_ACCS-1:0] slot_valid;
  logic [63:0]         slot_data [NUM_ACCS];
  logic [NUM_ACCS-1:0] accept;
  logic [NUM_ACCS-1:0] clear_vec;
  logic [ACC_BITS-1:0] rr_ptr;
  logic [ACC_BITS-1:0] grant;
  logic [ACC_BITS-1:0] cand;
  logic                grant_found;
  logic                out_valid;
  logic                load;
  int                  idx;

  assign acc_in_tready = {NUM_ACCS{rstn}} & ~slot_valid;
  assign accept        = acc_in_tvalid & acc_in_tready;
  assign load          = (~out_valid | cmdout_tready) & (|slot_valid);
  assign clear_vec     = {{(NUM_ACCS-1){1'b0}}, load} << grant;
  assign cmdout_tvalid = out_valid;

  // Rotating priority search starting at rr_ptr and wrapping modulo NUM_ACCS.
  always_comb begin
    grant       = rr_ptr;
    grant_found = 1'b0;
    idx         = 0;
    cand        = '0;
    for (int k = 0; k < NUM_ACCS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_ACCS) idx = idx - NUM_ACCS;
      cand = ACC_BITS'(idx);
      if (!grant_found && slot_valid[cand]) begin
        grant_found = 1'b1;
        grant       = cand;
      end
    end
  end

  // Accept and grant never target the same slot, since ready requires an empty slot.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_valid <= '0;
    end else begin
      slot_valid <= (slot_valid | accept) & ~clear_vec;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ACCS; i++) begin
      if (accept[i]) slot_data[i] <= acc_in_tdata[64*i +: 64];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid    <= 1'b0;
      cmdout_tid   <= '0;
      cmdout_tdata <= '0;
      rr_ptr       <= '0;
    end else if (load) begin
      out_valid    <= 1'b1;
      cmdout_tid   <= grant;
      cmdout_tdata <= slot_data[grant];
      rr_ptr       <= (grant == ACC_BITS'(NUM_ACCS-1)) ? '0 : grant + 1'b1;
    end else if (cmdout_tready) begin
      out_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      msg_count <= '0;
    end else if (out_valid && cmdout_tready) begin
      msg_count <= msg_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cmdout_collector.sv
// Bench for cmdout_collector with 5 sources and a 4-bit counter.
// Directed steps are followed by randomized traffic, and a per-source queue scoreboard checks order, loss and duplicates.
module tb_cmdout_collector;

  localparam int N  = 5;
  localparam int AB = 3;
  localparam int CW = 4;

  logic              clk;
  logic              rstn;
  logic [N-1:0]      acc_in_tvalid;
  logic [N-1:0]      acc_in_tready;
  logic [N*64-1:0]   acc_in_tdata;
  logic              cmdout_tvalid;
  logic              cmdout_tready;
  logic [AB-1:0]     cmdout_tid;
  logic [63:0]       cmdout_tdata;
  logic [CW-1:0]     msg_count;

  int checks = 0;
  int errors = 0;

  logic [63:0]   exp_q [N][$];
  logic [CW-1:0] model_cnt = '0;
  logic          prev_stall = 1'b0;
  logic [AB-1:0] prev_tid = '0;
  logic [63:0]   prev_data = '0;

  cmdout_collector #(.NUM_ACCS(N), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn),
    .acc_in_tvalid(acc_in_tvalid), .acc_in_tready(acc_in_tready), .acc_in_tdata(acc_in_tdata),
    .cmdout_tvalid(cmdout_tvalid), .cmdout_tready(cmdout_tready),
    .cmdout_tid(cmdout_tid), .cmdout_tdata(cmdout_tdata), .msg_count(msg_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench did not complete");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [63:0] d);
    acc_in_tvalid[i]          = v;
    acc_in_tdata[64*i +: 64]  = d;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    #1;
  endtask

  // Scoreboard: a word accepted from source i must leave later with tid=i, in source order.
  always @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) exp_q[i].delete();
      model_cnt  = '0;
      prev_stall = 1'b0;
    end else begin
      chk("msg_count", 64'(msg_count), 64'(model_cnt));
      if (prev_stall) begin
        chk("hold_valid", 64'(cmdout_tvalid), 64'(1));
        chk("hold_tid", 64'(cmdout_tid), 64'(prev_tid));
        chk("hold_data", cmdout_tdata, prev_data);
      end
      if (cmdout_tvalid && cmdout_tready) begin
        model_cnt = model_cnt + 1'b1;
        chk("tid_range", 64'(int'(cmdout_tid) < N), 64'(1));
        if (int'(cmdout_tid) < N) begin
          chk("sb_nonempty", 64'(exp_q[cmdout_tid].size() != 0), 64'(1));
          if (exp_q[cmdout_tid].size() != 0)
            chk("sb_data", cmdout_tdata, exp_q[cmdout_tid].pop_front());
        end
      end
      prev_stall = cmdout_tvalid && !cmdout_tready;
      prev_tid   = cmdout_tid;
      prev_data  = cmdout_tdata;
      for (int i = 0; i < N; i++)
        if (acc_in_tvalid[i] && acc_in_tready[i]) exp_q[i].push_back(acc_in_tdata[64*i +: 64]);
    end
  end

  initial begin
    logic [N-1:0] hsv;
    logic [63:0]  d0, d2, d4;
    logic         hs0, hs2, hs4;
    int           seen, gap, beats, sent, cyc, last_tid;

    rstn          = 1'b0;
    acc_in_tvalid = '0;
    acc_in_tdata  = '0;
    cmdout_tready = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(cmdout_tvalid), 64'(0));
    chk("rst_tready_low", 64'(acc_in_tready), 64'(0));
    chk("rst_count", 64'(msg_count), 64'(0));
    rstn = 1'b1;
    #1;
    chk("rel_tready", 64'(acc_in_tready), 64'h1f);
    chk("rel_tid", 64'(cmdout_tid), 64'(0));
    chk("rel_tdata", cmdout_tdata, 64'(0));

    // Single message from acc 3: valid two cycles after the input handshake
    cmdout_tready = 1'b1;
    drive(3, 1'b1, 64'h1122334455667788);
    tick();
    drive(3, 1'b0, 64'(0));
    chk("t1_tready3_busy", 64'(acc_in_tready[3]), 64'(0));
    chk("t1_tvalid_early", 64'(cmdout_tvalid), 64'(0));
    tick();
    chk("t1_tvalid", 64'(cmdout_tvalid), 64'(1));
    chk("t1_tid", 64'(cmdout_tid), 64'(3));
    chk("t1_tdata", cmdout_tdata, 64'h1122334455667788);
    chk("t1_tready3_free", 64'(acc_in_tready[3]), 64'(1));
    tick();
    chk("t1_tvalid_done", 64'(cmdout_tvalid), 64'(0));
    chk("t1_count", 64'(msg_count), 64'(1));

    // Simultaneous burst on 0..3 from rr_ptr=0, then a 4-then-0 wrap
    do_reset();
    for (int i = 0; i < 4; i++) drive(i, 1'b1, 64'hA0 + 64'(i));
    tick();
    for (int i = 0; i < 4; i++) drive(i, 1'b0, 64'(0));
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t2_tvalid", 64'(cmdout_tvalid), 64'(1));
      chk("t2_tid", 64'(cmdout_tid), 64'(k));
      chk("t2_tdata", cmdout_tdata, 64'hA0 + 64'(k));
    end
    drive(0, 1'b1, 64'hB0);
    drive(4, 1'b1, 64'hB4);
    tick();
    drive(0, 1'b0, 64'(0));
    drive(4, 1'b0, 64'(0));
    tick();
    chk("t2_count", 64'(msg_count), 64'(4));
    chk("t2_wrap_tid4", 64'(cmdout_tid), 64'(4));
    chk("t2_wrap_data4", cmdout_tdata, 64'hB4);
    tick();
    chk("t2_wrap_tid0", 64'(cmdout_tid), 64'(0));
    chk("t2_wrap_data0", cmdout_tdata, 64'hB0);
    tick();
    chk("t2_idle", 64'(cmdout_tvalid), 64'(0));

    // Backpressure: tid 1 held stable; slot 1 already moved to the output, slot 2 stays full
    cmdout_tready = 1'b0;
    drive(1, 1'b1, 64'hC1C1_0000_0000_0001);
    drive(2, 1'b1, 64'hC2C2_0000_0000_0002);
    tick();
    drive(1, 1'b0, 64'(0));
    drive(2, 1'b0, 64'(0));
    tick();
    for (int k = 0; k < 10; k++) begin
      chk("t3_valid", 64'(cmdout_tvalid), 64'(1));
      chk("t3_tid", 64'(cmdout_tid), 64'(1));
      chk("t3_data", cmdout_tdata, 64'hC1C1_0000_0000_0001);
      chk("t3_tready2", 64'(acc_in_tready[2]), 64'(0));
      chk("t3_tready1", 64'(acc_in_tready[1]), 64'(1));
      tick();
    end
    cmdout_tready = 1'b1;
    tick();
    chk("t3_next_tid", 64'(cmdout_tid), 64'(2));
    chk("t3_next_data", cmdout_tdata, 64'hC2C2_0000_0000_0002);
    tick();
    chk("t3_idle", 64'(cmdout_tvalid), 64'(0));

    // Fairness: 0 and 2 always valid; output must alternate starting from 0 (rr_ptr=3)
    d0 = 64'h1000;
    d2 = 64'h2000;
    drive(0, 1'b1, d0);
    drive(2, 1'b1, d2);
    seen = 0;
    gap = 0;
    last_tid = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      hs0 = acc_in_tvalid[0] & acc_in_tready[0];
      hs2 = acc_in_tvalid[2] & acc_in_tready[2];
      if (cmdout_tvalid) begin
        chk("t4_alt_tid", 64'(cmdout_tid), 64'((seen == 0) ? 0 : ((last_tid == 0) ? 2 : 0)));
        last_tid = int'(cmdout_tid);
        seen++;
        gap = 0;
      end else if (seen > 0) begin
        gap++;
        chk("t4_gap", 64'(gap <= 1), 64'(1));
      end
      @(posedge clk);
      #1;
      if (hs0) begin d0 = d0 + 1; drive(0, 1'b1, d0); end
      if (hs2) begin d2 = d2 + 1; drive(2, 1'b1, d2); end
    end
    drive(0, 1'b0, 64'(0));
    drive(2, 1'b0, 64'(0));
    repeat (4) tick();

    // Reset mid-operation with slots 0..3 full and the output occupied
    do_reset();
    cmdout_tready = 1'b0;
    for (int i = 0; i < 4; i++) drive(i, 1'b1, 64'hD0 + 64'(i));
    tick();
    for (int i = 1; i < 4; i++) drive(i, 1'b0, 64'(0));
    drive(0, 1'b1, 64'hD4);
    tick();
    tick();
    drive(0, 1'b0, 64'(0));
    chk("t5_pre_valid", 64'(cmdout_tvalid), 64'(1));
    chk("t5_pre_tready", 64'(acc_in_tready), 64'h10);
    #1;
    rstn = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(cmdout_tvalid), 64'(0));
    chk("t5_rst_tready", 64'(acc_in_tready), 64'(0));
    chk("t5_rst_tdata", cmdout_tdata, 64'(0));
    chk("t5_rst_count", 64'(msg_count), 64'(0));
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("t5_rel_tready", 64'(acc_in_tready), 64'h1f);
    cmdout_tready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t5_no_stale", 64'(cmdout_tvalid), 64'(0));
    end
    chk("t5_count", 64'(msg_count), 64'(0));

    // Counter wrap: 17 messages from acc 4 with a 4-bit counter leave it at 1
    @(posedge clk);
    #1;
    d4 = 64'hE00;
    drive(4, 1'b1, d4);
    beats = 0;
    sent = 0;
    cyc = 0;
    while (beats < 17 && cyc < 200) begin
      cyc++;
      @(negedge clk);
      hs4 = acc_in_tvalid[4] & acc_in_tready[4];
      if (cmdout_tvalid && cmdout_tready) begin
        chk("t6_tid", 64'(cmdout_tid), 64'(4));
        beats++;
      end
      @(posedge clk);
      #1;
      if (hs4) begin
        sent++;
        d4 = d4 + 1;
        if (sent == 17) drive(4, 1'b0, 64'(0));
        else drive(4, 1'b1, d4);
      end
    end
    chk("t6_beats", 64'(beats), 64'(17));
    chk("t6_count_wrap", 64'(msg_count), 64'(1));
    drive(0, 1'b1, 64'hF0);
    drive(4, 1'b1, 64'hF4);
    tick();
    drive(0, 1'b0, 64'(0));
    drive(4, 1'b0, 64'(0));
    tick();
    chk("t6_rr_wrap_tid", 64'(cmdout_tid), 64'(0));
    tick();
    chk("t6_rr_next_tid", 64'(cmdout_tid), 64'(4));
    tick();

    // Randomized traffic; sources keep valid asserted until their handshake
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      hsv = acc_in_tvalid & acc_in_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (!acc_in_tvalid[i] || hsv[i]) begin
          if ($urandom_range(0, 2) != 0) drive(i, 1'b1, {$urandom, $urandom});
          else drive(i, 1'b0, 64'(0));
        end
      end
      cmdout_tready = ($urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < N; i++) drive(i, 1'b0, 64'(0));
    cmdout_tready = 1'b1;
    repeat (20) tick();
    for (int i = 0; i < N; i++) chk("drain_empty", 64'(exp_q[i].size()), 64'(0));
    chk("drain_idle", 64'(cmdout_tvalid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
